// File: rtl/flit_writer.sv
// Feeds 1- or 2-flit packets into the flit buffer: waits for capacity, strobes
// each flit with setup/hold margin, then resends on nack or drops the packet.
module flit_writer #(
    parameter int FLIT_W    = 32,
    parameter int CAP_W     = 3,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic              pkt_len,
    input  logic [FLIT_W-1:0] pkt_flit0,
    input  logic [FLIT_W-1:0] pkt_flit1,
    output logic [FLIT_W-1:0] buf_in,
    output logic              buf_write,
    input  logic              buf_ack,
    input  logic [CAP_W-1:0]  buf_capacity,
    output logic              pkt_done,
    output logic              pkt_drop,
    output logic              busy
);

    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_ACK
    } state_t;

    state_t              state_q, state_d;
    logic                len_q, len_d;
    logic                idx_q, idx_d;
    logic [FLIT_W-1:0]   flit_q [0:1];
    logic [FLIT_W-1:0]   flit_d [0:1];
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [FLIT_W-1:0]   buf_in_q, buf_in_d;
    logic                buf_write_q, buf_write_d;
    logic                pkt_done_q, pkt_done_d;
    logic                pkt_drop_q, pkt_drop_d;
    logic                busy_q, busy_d;
    logic                pkt_ready_q, pkt_ready_d;

    logic [FLIT_W-1:0]   src_flit [0:1];
    logic [FLIT_W-1:0]   fmt_flit [0:1];
    logic [WAIT_W-1:0]   wait_inc;
    logic [RETRY_W-1:0]  retry_inc;
    logic [CAP_W:0]      cap_need;
    logic                cap_ok;

    assign src_flit[0] = pkt_flit0;
    assign src_flit[1] = pkt_flit1;

    // Bit0 carries the flit index; the header's bit1 carries the packet length.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fmt
            assign fmt_flit[gi] = {src_flit[gi][FLIT_W-1:2],
                                   (gi == 0) ? pkt_len : src_flit[gi][1],
                                   (gi == 1) ? 1'b1 : 1'b0};
        end
    endgenerate

    // Both counters hold at their limit rather than wrapping.
    assign wait_inc  = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
    assign retry_inc = (retry_q == RETRY_W'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;

    assign cap_need = len_q ? (CAP_W+1)'(2) : (CAP_W+1)'(1);
    assign cap_ok   = ({1'b0, buf_capacity} >= cap_need);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        flit_d     = flit_q;
        wait_d     = wait_q;
        retry_d    = retry_q;
        pkt_done_d = 1'b0;
        pkt_drop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid && pkt_ready_q) begin
                    len_d     = pkt_len;
                    flit_d[0] = fmt_flit[0];
                    flit_d[1] = fmt_flit[1];
                    idx_d     = 1'b0;
                    wait_d    = '0;
                    retry_d   = '0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cap_ok) begin
                    state_d = S_SETUP;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc >= WAIT_W'(TIMEOUT)) begin
                        pkt_drop_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (!idx_q && len_q) begin
                    idx_d   = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (buf_ack) begin
                    pkt_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc >= RETRY_W'(MAX_RETRY)) begin
                        pkt_drop_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d   = 1'b0;
                        wait_d  = '0;
                        state_d = S_CHECK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        buf_write_d = (state_d == S_STROBE);
        busy_d      = (state_d != S_IDLE);
        pkt_ready_d = (state_d == S_IDLE);
        buf_in_d    = (state_d == S_SETUP) ? flit_d[idx_d] : buf_in_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 1'b0;
            idx_q       <= 1'b0;
            flit_q[0]   <= '0;
            flit_q[1]   <= '0;
            wait_q      <= '0;
            retry_q     <= '0;
            buf_in_q    <= '0;
            buf_write_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_drop_q  <= 1'b0;
            busy_q      <= 1'b0;
            pkt_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            flit_q[0]   <= flit_d[0];
            flit_q[1]   <= flit_d[1];
            wait_q      <= wait_d;
            retry_q     <= retry_d;
            buf_in_q    <= buf_in_d;
            buf_write_q <= buf_write_d;
            pkt_done_q  <= pkt_done_d;
            pkt_drop_q  <= pkt_drop_d;
            busy_q      <= busy_d;
            pkt_ready_q <= pkt_ready_d;
        end
    end

    assign buf_in    = buf_in_q;
    assign buf_write = buf_write_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_drop  = pkt_drop_q;
    assign busy      = busy_q;
    assign pkt_ready = pkt_ready_q;

endmodule
